// File: rtl/lfsr_cipher_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lfsr_cipher_pkg
// Description : Shared types and constants for the LFSR cipher engine:
//               frame state encoding, space character, default tap table,
//               preamble clamp defaults and the clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_cipher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MSG  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_SPACE           = 8'h20;
    localparam int         c_PRE_MIN_DEFAULT = 10;
    localparam int         c_PRE_MAX_DEFAULT = 26;
    localparam logic [7:0] c_PTRN_EXT_SEL    = 8'd8;

    // Entries 0..7 are reached by PtrnSel[2:0]; entry 8 only by PtrnSel == 8.
    localparam logic [7:0] c_TAP_TABLE [0:8] = '{
        8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B
    };

    function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (len < lo) return lo;
        if (len > hi) return hi;
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_cipher_engine_if.sv
`default_nettype none
// ============================================================================
// Interface   : lfsr_cipher_engine_if
// Description : Frame configuration, input character stream, output
//               character stream and status of the LFSR cipher engine.
//               master = frame source/sink, slave = engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_cipher_engine_if #(
    parameter int LFSR_W = 7
);
    logic              Start;
    logic              Mode;
    logic [7:0]        PreLen;
    logic [7:0]        PtrnSel;
    logic [LFSR_W-1:0] LfsrInit;
    logic [7:0]        InData;
    logic              InValid;
    logic              InLast;
    logic              InReady;
    logic [7:0]        OutData;
    logic              OutValid;
    logic              OutReady;
    logic              Ack;
    logic [7:0]        ParityErrs;

    modport master (
        output Start, Mode, PreLen, PtrnSel, LfsrInit,
        output InData, InValid, InLast, OutReady,
        input  InReady, OutData, OutValid, Ack, ParityErrs
    );

    modport slave (
        input  Start, Mode, PreLen, PtrnSel, LfsrInit,
        input  InData, InValid, InLast, OutReady,
        output InReady, OutData, OutValid, Ack, ParityErrs
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_step
// Description : Combinational next state of a Fibonacci-style shift-left LFSR
//               whose feedback bit is the parity of the tapped state bits.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step #(
    parameter int LFSR_W = 7
) (
    input  wire logic [LFSR_W-1:0] i_state,
    input  wire logic [LFSR_W-1:0] i_taps,
    output logic      [LFSR_W-1:0] o_next
);

    // Shift left, feedback enters at bit 0.
    assign o_next = {i_state[LFSR_W-2:0], ^(i_state & i_taps)};

endmodule
`default_nettype wire

// File: rtl/lfsr_cipher_engine.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_cipher_engine
// Description : Frame-based stream cipher. Encrypt: preamble of spaces,
//               message, space padding up to FRAME_LEN characters, each XORed
//               with an LFSR keystream and given an even-parity bit 7.
//               Decrypt: FRAME_LEN characters XORed with the same keystream,
//               with a saturating parity-error count.
//               Build option: define LFSR_CIPHER_DECRYPT_EN to enable decrypt
//               mode and the parity checker.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_cipher_engine
    import lfsr_cipher_pkg::*;
#(
    parameter int LFSR_W    = 7,
    parameter int FRAME_LEN = 64,
    parameter int PRE_MIN   = c_PRE_MIN_DEFAULT,
    parameter int PRE_MAX   = c_PRE_MAX_DEFAULT
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    lfsr_cipher_engine_if.slave bus
);

    localparam int                 c_CNT_W      = $clog2(FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_END  = c_CNT_W'(FRAME_LEN);

    state_t             r_state;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  r_taps;
    logic [c_CNT_W-1:0] r_pre_len;
    logic [c_CNT_W-1:0] r_load_cnt;
    logic [c_CNT_W-1:0] r_hs_cnt;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic               r_ack;

    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [LFSR_W-1:0]  w_key;
    logic [3:0]         w_ptrn_idx;
    logic               w_start;
    logic               w_start_decrypt;
    logic               w_decrypt;
    logic               w_out_hs;
    logic               w_can_load;
    logic               w_room;
    logic               w_in_ready;
    logic               w_in_hs;
    logic               w_load_space;
    logic               w_load;
    logic [6:0]         w_src;
    logic [6:0]         w_cipher;
    logic [7:0]         w_out_next;

    lfsr_step #(
        .LFSR_W (LFSR_W)
    ) u_lfsr_step (
        .i_state (r_lfsr),
        .i_taps  (r_taps),
        .o_next  (w_lfsr_next)
    );

    assign w_start    = (r_state == ST_IDLE) && bus.Start;
    assign w_ptrn_idx = (bus.PtrnSel == c_PTRN_EXT_SEL) ? 4'd8 : {1'b0, bus.PtrnSel[2:0]};

    // The output register may take a new character when empty or when its
    // current character is being accepted this cycle.
    assign w_out_hs     = r_out_valid && bus.OutReady;
    assign w_can_load   = !r_out_valid || bus.OutReady;
    assign w_room       = (r_load_cnt != c_FRAME_END);
    assign w_in_ready   = !Reset && (r_state == ST_MSG) && w_can_load && w_room;
    assign w_in_hs      = w_in_ready && bus.InValid;
    assign w_load_space = w_can_load && w_room && ((r_state == ST_PRE) || (r_state == ST_POST));
    assign w_load       = w_in_hs || w_load_space;

    // The LFSR counts output handshakes; a character loaded while its
    // predecessor drains must use the state after that handshake.
    assign w_key      = w_out_hs ? w_lfsr_next : r_lfsr;
    assign w_src      = w_load_space ? c_SPACE[6:0] : bus.InData[6:0];
    assign w_cipher   = w_src ^ w_key[6:0];
    assign w_out_next = w_decrypt ? {1'b0, w_cipher} : {^w_cipher, w_cipher};

    // Frame sequencing, keystream, output register and completion pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_W'(1);
            r_taps      <= '0;
            r_pre_len   <= '0;
            r_load_cnt  <= '0;
            r_hs_cnt    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_out_hs) begin
                r_lfsr   <= w_lfsr_next;
                r_hs_cnt <= r_hs_cnt + c_CNT_W'(1);
            end
            if (w_load) begin
                r_out_data  <= w_out_next;
                r_out_valid <= 1'b1;
                r_load_cnt  <= r_load_cnt + c_CNT_W'(1);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_lfsr     <= (bus.LfsrInit == '0) ? LFSR_W'(1) : bus.LfsrInit;
                        r_taps     <= LFSR_W'(c_TAP_TABLE[w_ptrn_idx]);
                        r_pre_len  <= c_CNT_W'(clamp_len(bus.PreLen, 8'(PRE_MIN), 8'(PRE_MAX)));
                        r_load_cnt <= '0;
                        r_hs_cnt   <= '0;
                        r_state    <= w_start_decrypt ? ST_MSG : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (w_load_space && (r_load_cnt == r_pre_len - c_CNT_W'(1)))
                        r_state <= ST_MSG;
                end
                ST_MSG: begin
                    // Leaves on InLast (encrypt) or when the frame is full.
                    if (w_in_hs && ((!w_decrypt && bus.InLast) || (r_load_cnt == c_FRAME_LAST)))
                        r_state <= ST_POST;
                end
                ST_POST: begin
                    if (w_out_hs && (r_hs_cnt == c_FRAME_LAST)) begin
                        r_state <= ST_DONE;
                        r_ack   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_CIPHER_DECRYPT_EN
    logic       r_mode;
    logic [7:0] r_parity_errs;

    assign w_start_decrypt = bus.Mode;
    assign w_decrypt       = r_mode;

    // Frame direction, captured when a frame is launched.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_mode <= 1'b0;
        else if (w_start)
            r_mode <= bus.Mode;
    end

    // Saturating count of received characters whose bit 7 breaks even parity.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_parity_errs <= '0;
        else if (w_start)
            r_parity_errs <= '0;
        else if (w_in_hs && r_mode && (bus.InData[7] != ^bus.InData[6:0])
                 && (r_parity_errs != 8'hFF))
            r_parity_errs <= r_parity_errs + 8'd1;
    end

    assign bus.ParityErrs = r_parity_errs;
`else
    logic w_unused_cfg;

    assign w_start_decrypt = 1'b0;
    assign w_decrypt       = 1'b0;
    assign w_unused_cfg    = ^{bus.Mode, bus.InData[7]};
    assign bus.ParityErrs  = 8'd0;
`endif

    assign bus.InReady  = w_in_ready;
    assign bus.OutData  = r_out_data;
    assign bus.OutValid = r_out_valid;
    assign bus.Ack      = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_cipher_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_cipher_engine
// Description : Scoreboard bench for lfsr_cipher_engine. Each frame's expected
//               output characters are queued at launch and compared as the
//               engine emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_cipher_engine;

    localparam int c_FRAME_LEN = 64;
    localparam int c_TIMEOUT   = 2000;
`ifdef LFSR_CIPHER_DECRYPT_EN
    localparam bit c_DEC_EN = 1'b1;
`else
    localparam bit c_DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    lfsr_cipher_engine_if #(.LFSR_W(7)) bus ();

    lfsr_cipher_engine #(
        .LFSR_W    (7),
        .FRAME_LEN (c_FRAME_LEN),
        .PRE_MIN   (10),
        .PRE_MAX   (26)
    ) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q_exp [$];
    logic [7:0] msg [$];
    logic [7:0] plain  [c_FRAME_LEN];
    logic [7:0] cipher [c_FRAME_LEN];
    logic [7:0] cap_out [2];
    int         n_out       = 0;
    int         ack_cnt     = 0;
    int         cyc         = 0;
    int         last_hs_cyc = 0;
    int         stall_at    = -1;
    int         stall_left  = 0;
    bit         rand_ready  = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp_pre(input logic [7:0] v);
        if (v < 8'd10) return 10;
        if (v > 8'd26) return 26;
        return int'(v);
    endfunction

    function automatic logic [6:0] taps_for(input logic [7:0] sel);
        int idx;
        idx = (sel == 8'd8) ? 8 : int'(sel[2:0]);
        case (idx)
            0: return 7'h60;
            1: return 7'h48;
            2: return 7'h78;
            3: return 7'h72;
            4: return 7'h6A;
            5: return 7'h69;
            6: return 7'h5C;
            7: return 7'h7E;
            default: return 7'h7B;
        endcase
    endfunction

    task automatic build_plain(input logic [7:0] pre_len, output int n_used, output bit trunc);
        int p;
        int k;
        p = clamp_pre(pre_len);
        k = 0;
        for (int i = 0; i < c_FRAME_LEN; i++) begin
            if (i >= p && k < msg.size()) begin
                plain[i] = msg[k];
                k++;
            end else begin
                plain[i] = 8'h20;
            end
        end
        n_used = k;
        trunc  = (k < msg.size());
    endtask

    task automatic encrypt_plain(input logic [6:0] taps, input logic [6:0] init);
        logic [6:0] s;
        logic [6:0] c;
        s = (init == 7'd0) ? 7'd1 : init;
        for (int i = 0; i < c_FRAME_LEN; i++) begin
            c         = plain[i][6:0] ^ s;
            cipher[i] = {^c, c};
            s         = {s[5:0], ^(s & taps)};
        end
    endtask

    task automatic set_msg(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    // ---------------- output monitor / scoreboard ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && bus.OutValid) begin
            check_value("out_expected", 32'(q_exp.size() != 0), 32'd1);
            if (q_exp.size() != 0) begin
                check_value($sformatf("out_data[%0d]", n_out), {24'd0, bus.OutData}, {24'd0, q_exp[0]});
                if (bus.OutReady) begin
                    if (n_out < 2) cap_out[n_out] = bus.OutData;
                    void'(q_exp.pop_front());
                    n_out++;
                    last_hs_cyc = cyc;
                end
            end
        end
        if (!rst && bus.Ack) begin
            ack_cnt++;
            check_value("ack_one_cycle_after_last", cyc, last_hs_cyc + 1);
            check_value("ack_output_count", n_out, c_FRAME_LEN);
        end
    end

    // Output back-pressure: always ready, random, or a 5-cycle stall window.
    initial begin
        bus.OutReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                bus.OutReady = 1'b0;
                stall_left--;
            end else if (stall_at >= 0 && n_out >= stall_at) begin
                bus.OutReady = 1'b0;
                stall_left   = 4;
                stall_at     = -1;
            end else begin
                bus.OutReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input bit dec, input logic [7:0] pre_len,
                               input logic [7:0] ptrn, input logic [6:0] init);
        @(posedge clk);
        #1;
        bus.Start    = 1'b1;
        bus.Mode     = dec;
        bus.PreLen   = pre_len;
        bus.PtrnSel  = ptrn;
        bus.LfsrInit = init;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic feed_char(input logic [7:0] din, input bit last, output bit ok);
        int waited;
        bus.InData  = din;
        bus.InLast  = last;
        bus.InValid = 1'b1;
        waited      = 0;
        @(negedge clk);
        while (!bus.InReady && waited < c_TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check_value("in_ready", {31'd0, bus.InReady}, 32'd1);
        ok = bus.InReady;
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
        bus.InLast  = 1'b0;
    endtask

    task automatic run_frame(input bit dec, input logic [7:0] pre_len, input logic [7:0] ptrn,
                             input logic [6:0] init, input int n_flip);
        int         n_used;
        int         n_feed;
        int         waited;
        bit         trunc;
        bit         trunc_enc;
        bit         dec_eff;
        bit         ok;
        bit         saw_ready;
        logic [7:0] din;
        dec_eff = dec && c_DEC_EN;
        build_plain(pre_len, n_used, trunc);
        encrypt_plain(taps_for(ptrn), init);
        trunc_enc = trunc && !dec_eff;
        for (int i = 0; i < c_FRAME_LEN; i++)
            q_exp.push_back(dec_eff ? {1'b0, plain[i][6:0]} : cipher[i]);
        n_feed  = dec_eff ? c_FRAME_LEN : n_used;
        n_out   = 0;
        ack_cnt = 0;
        start_frame(dec, pre_len, ptrn, init);
        ok = 1'b1;
        for (int i = 0; i < n_feed && ok; i++) begin
            din = dec_eff ? cipher[i] : msg[i];
            if (dec_eff && ((i == 3 && n_flip > 0) || (i == 20 && n_flip > 1) || (i == 40 && n_flip > 2)))
                din[7] = ~din[7];
            feed_char(din, dec_eff ? (i == 5) : (i == msg.size() - 1), ok);
            if (i % 4 == 3) begin
                @(posedge clk);
                #1;
            end
        end
        saw_ready = 1'b0;
        if (trunc_enc) begin
            bus.InData  = msg[n_used];
            bus.InValid = 1'b1;
        end
        waited = 0;
        while (ack_cnt == 0 && waited < c_TIMEOUT) begin
            @(negedge clk);
            waited++;
            if (bus.InValid && bus.InReady) saw_ready = 1'b1;
        end
        repeat (4) @(negedge clk);
        bus.InValid = 1'b0;
        check_value("ack_once", ack_cnt, 1);
        check_value("frame_outputs", n_out, c_FRAME_LEN);
        check_value("queue_drained", q_exp.size(), 0);
        if (trunc_enc) check_value("truncated_in_ready", {31'd0, saw_ready}, 32'd0);
        check_value("parity_errs", {24'd0, bus.ParityErrs}, dec_eff ? n_flip : 0);
        q_exp.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        int waited;
        rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.Mode     = 1'b0;
        bus.PreLen   = 8'd0;
        bus.PtrnSel  = 8'd0;
        bus.LfsrInit = 7'd0;
        bus.InData   = 8'd0;
        bus.InValid  = 1'b0;
        bus.InLast   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", {31'd0, bus.OutValid}, 32'd0);
        check_value("rst_out_data", {24'd0, bus.OutData}, 32'd0);
        check_value("rst_in_ready", {31'd0, bus.InReady}, 32'd0);
        check_value("rst_ack", {31'd0, bus.Ack}, 32'd0);
        check_value("rst_parity", {24'd0, bus.ParityErrs}, 32'd0);
        rst = 1'b0;

        // Basic encrypt frame with known first keystream characters.
        set_msg("A");
        run_frame(1'b0, 8'd10, 8'd0, 7'd1, 0);
        check_value("basic_out0", {24'd0, cap_out[0]}, 32'h21);
        check_value("basic_out1", {24'd0, cap_out[1]}, 32'h22);

        // Preamble clamps, tap selection, zero seed.
        set_msg("HELLO");
        run_frame(1'b0, 8'd3, 8'd2, 7'h55, 0);
        set_msg("WORLD");
        run_frame(1'b0, 8'd200, 8'd5, 7'h11, 0);
        set_msg("XYZ");
        run_frame(1'b0, 8'd15, 8'd8, 7'd0, 0);
        set_msg("Q");
        run_frame(1'b0, 8'd12, 8'd13, 7'h3A, 0);

        // Output stall of 5 cycles in the middle of the message.
        set_msg("STALLED-MESSAGE-TEXT");
        stall_at = 13;
        run_frame(1'b0, 8'd10, 8'd3, 7'h2B, 0);

        // Random back-pressure with a message that overflows the frame.
        msg.delete();
        for (int i = 0; i < 60; i++) msg.push_back(8'(8'h30 + (i % 40)));
        rand_ready = 1'b1;
        run_frame(1'b0, 8'd10, 8'd6, 7'h47, 0);
        rand_ready = 1'b0;

        // Decrypt of the basic frame: with 3 parity flips, then clean.
        set_msg("A");
        run_frame(1'b1, 8'd10, 8'd0, 7'd1, 3);
        run_frame(1'b1, 8'd10, 8'd0, 7'd1, 0);

        // Reset in the middle of a frame.
        set_msg("A");
        build_plain(8'd10, waited, ok);
        encrypt_plain(taps_for(8'd0), 7'd1);
        for (int i = 0; i < c_FRAME_LEN; i++) q_exp.push_back(cipher[i]);
        n_out   = 0;
        ack_cnt = 0;
        start_frame(1'b0, 8'd10, 8'd0, 7'd1);
        feed_char(8'h41, 1'b1, ok);
        waited = 0;
        while (n_out < 30 && waited < c_TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check_value("reached_output_30", {31'd0, n_out >= 30}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_exp.delete();
        check_value("midrst_out_valid", {31'd0, bus.OutValid}, 32'd0);
        check_value("midrst_out_data", {24'd0, bus.OutData}, 32'd0);
        check_value("midrst_in_ready", {31'd0, bus.InReady}, 32'd0);
        check_value("midrst_ack", {31'd0, bus.Ack}, 32'd0);
        check_value("midrst_parity", {24'd0, bus.ParityErrs}, 32'd0);
        repeat (80) @(negedge clk);
        check_value("midrst_no_ack", ack_cnt, 0);
        check_value("midrst_idle", {31'd0, bus.OutValid}, 32'd0);

        // Reset wins over a simultaneous Start.
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.Start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.Start = 1'b0;
        repeat (6) @(negedge clk);
        check_value("rst_over_start", {31'd0, bus.OutValid}, 32'd0);

        // Clean frame after reset.
        set_msg("A");
        run_frame(1'b0, 8'd10, 8'd0, 7'd1, 0);
        check_value("post_rst_out0", {24'd0, cap_out[0]}, 32'h21);
        check_value("post_rst_out1", {24'd0, cap_out[1]}, 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
